// File: rtl/ahbl_addr_splitter_if.sv
// Bus bundle for the 1:N AHB-Lite splitter: upstream master signals on src_*,
// per-slave fanout on dst_*, plus the registered data-phase select.
interface ahbl_addr_splitter_if #(
   parameter int N_PORTS = 2,
   parameter int W_ADDR  = 32,
   parameter int W_DATA  = 32
);
   logic                       src_hready;
   logic                       src_hready_resp;
   logic                       src_hresp;
   logic [W_ADDR-1:0]          src_haddr;
   logic                       src_hwrite;
   logic [1:0]                 src_htrans;
   logic [2:0]                 src_hsize;
   logic [2:0]                 src_hburst;
   logic [3:0]                 src_hprot;
   logic                       src_hmastlock;
   logic                       src_hexcl;
   logic [7:0]                 src_hmaster;
   logic [W_DATA-1:0]          src_hwdata;
   logic [W_DATA-1:0]          src_hrdata;
   logic                       src_hexokay;

   logic [N_PORTS-1:0]         dst_hready;
   logic [N_PORTS-1:0]         dst_hready_resp;
   logic [N_PORTS-1:0]         dst_hresp;
   logic [N_PORTS-1:0]         dst_hexokay;
   logic [N_PORTS*W_ADDR-1:0]  dst_haddr;
   logic [N_PORTS-1:0]         dst_hwrite;
   logic [N_PORTS*2-1:0]       dst_htrans;
   logic [N_PORTS*3-1:0]       dst_hsize;
   logic [N_PORTS*3-1:0]       dst_hburst;
   logic [N_PORTS*4-1:0]       dst_hprot;
   logic [N_PORTS-1:0]         dst_hmastlock;
   logic [N_PORTS-1:0]         dst_hexcl;
   logic [N_PORTS*8-1:0]       dst_hmaster;
   logic [N_PORTS*W_DATA-1:0]  dst_hwdata;
   logic [N_PORTS*W_DATA-1:0]  dst_hrdata;

   logic [N_PORTS-1:0]         slave_sel_d;

   // The splitter itself.
   modport slave (
      input  src_hready, src_haddr, src_hwrite, src_htrans, src_hsize, src_hburst,
             src_hprot, src_hmastlock, src_hexcl, src_hmaster, src_hwdata,
             dst_hready_resp, dst_hresp, dst_hexokay, dst_hrdata,
      output src_hready_resp, src_hresp, src_hrdata, src_hexokay,
             dst_hready, dst_haddr, dst_hwrite, dst_htrans, dst_hsize, dst_hburst,
             dst_hprot, dst_hmastlock, dst_hexcl, dst_hmaster, dst_hwdata,
             slave_sel_d
   );

   // The surrounding system: upstream master plus the downstream slaves.
   modport master (
      output src_hready, src_haddr, src_hwrite, src_htrans, src_hsize, src_hburst,
             src_hprot, src_hmastlock, src_hexcl, src_hmaster, src_hwdata,
             dst_hready_resp, dst_hresp, dst_hexokay, dst_hrdata,
      input  src_hready_resp, src_hresp, src_hrdata, src_hexokay,
             dst_hready, dst_haddr, dst_hwrite, dst_htrans, dst_hsize, dst_hburst,
             dst_hprot, dst_hmastlock, dst_hexcl, dst_hmaster, dst_hwdata,
             slave_sel_d
   );
endinterface

// File: rtl/ahbl_addr_splitter.sv
// 1:N AHB-Lite address splitter: base/mask decode, registered data-phase owner,
// response mux, and a local two-cycle ERROR response for unmapped addresses.
module ahbl_addr_splitter #(
   parameter int N_PORTS = 2,
   parameter int W_ADDR  = 32,
   parameter int W_DATA  = 32,
   parameter logic [N_PORTS*W_ADDR-1:0] ADDR_MAP  = '0,
   parameter logic [N_PORTS*W_ADDR-1:0] ADDR_MASK = '0
) (
   input  logic                clk,
   input  logic                rst_n,
   ahbl_addr_splitter_if.slave bus
);
   typedef enum logic [1:0] {ST_IDLE, ST_ERR1, ST_ERR2} err_state_t;

   err_state_t         state;
   logic [N_PORTS-1:0] sel_a;
   logic [N_PORTS-1:0] sel_d;
   logic               active;
   logic               unmapped;

   assign active   = bus.src_htrans[1];
   assign unmapped = active && (sel_a == '0);

   // Lowest matching window wins, so sel_a is one-hot or zero.
   always_comb begin
      logic taken;
      sel_a = '0;
      taken = 1'b0;
      for (int i = 0; i < N_PORTS; i++) begin
         if (!taken && ((bus.src_haddr & ADDR_MASK[i*W_ADDR +: W_ADDR]) ==
                        ADDR_MAP[i*W_ADDR +: W_ADDR])) begin
            sel_a[i] = 1'b1;
            taken    = 1'b1;
         end
      end
   end

   assign bus.dst_hready    = {N_PORTS{bus.src_hready}};
   assign bus.dst_haddr     = {N_PORTS{bus.src_haddr}};
   assign bus.dst_hwrite    = {N_PORTS{bus.src_hwrite}};
   assign bus.dst_hsize     = {N_PORTS{bus.src_hsize}};
   assign bus.dst_hburst    = {N_PORTS{bus.src_hburst}};
   assign bus.dst_hprot     = {N_PORTS{bus.src_hprot}};
   assign bus.dst_hmastlock = {N_PORTS{bus.src_hmastlock}};
   assign bus.dst_hexcl     = {N_PORTS{bus.src_hexcl}};
   assign bus.dst_hmaster   = {N_PORTS{bus.src_hmaster}};
   assign bus.dst_hwdata    = {N_PORTS{bus.src_hwdata}};

   for (genvar i = 0; i < N_PORTS; i++) begin : g_port
      assign bus.dst_htrans[2*i +: 2] = (active && sel_a[i]) ? bus.src_htrans : 2'b00;
   end

   // Error states leave the slave outputs out of the response path entirely.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
         sel_d <= '0;
      end else begin
         if (bus.src_hready) begin
            sel_d <= active ? sel_a : '0;
         end
         case (state)
            ST_IDLE: if (bus.src_hready && unmapped) state <= ST_ERR1;
            ST_ERR1: state <= ST_ERR2;
            ST_ERR2: state <= (bus.src_hready && unmapped) ? ST_ERR1 : ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign bus.slave_sel_d = sel_d;

   always_comb begin
      logic [W_DATA-1:0] rdata;
      rdata = '0;
      for (int i = 0; i < N_PORTS; i++) begin
         rdata = rdata | (bus.dst_hrdata[i*W_DATA +: W_DATA] & {W_DATA{sel_d[i]}});
      end
      bus.src_hready_resp = 1'b1;
      bus.src_hresp       = 1'b0;
      bus.src_hexokay     = 1'b0;
      bus.src_hrdata      = '0;
      if (state == ST_ERR1) begin
         bus.src_hready_resp = 1'b0;
         bus.src_hresp       = 1'b1;
      end else if (state == ST_ERR2) begin
         bus.src_hresp       = 1'b1;
      end else if (sel_d != '0) begin
         bus.src_hready_resp = |(sel_d & bus.dst_hready_resp);
         bus.src_hresp       = |(sel_d & bus.dst_hresp);
         bus.src_hexokay     = |(sel_d & bus.dst_hexokay);
         bus.src_hrdata      = rdata;
      end
   end
endmodule

// File: tb/tb_ahbl_addr_splitter.sv
// Directed and randomized checks of ahbl_addr_splitter against a transfer-level
// model of which slave (or the local error response) owns each data phase.
module tb_ahbl_addr_splitter;
   localparam int NP = 2;
   localparam int WA = 32;
   localparam int WD = 32;
   localparam logic [NP*WA-1:0] MAP  = {32'h4000_0000, 32'h0000_0000};
   localparam logic [NP*WA-1:0] MASK = {32'hF000_0000, 32'hF000_0000};

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic hold_low = 1'b0;
   int   checks = 0;
   int   failures = 0;

   ahbl_addr_splitter_if #(.N_PORTS(NP), .W_ADDR(WA), .W_DATA(WD)) bus ();

   ahbl_addr_splitter #(
      .N_PORTS(NP), .W_ADDR(WA), .W_DATA(WD), .ADDR_MAP(MAP), .ADDR_MASK(MASK)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus)
   );

   always #5 clk = ~clk;

   // Single-master bus: HREADY is the splitter's own HREADYOUT unless forced low.
   assign bus.src_hready = bus.src_hready_resp & ~hold_low;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [1:0] tr, input logic [31:0] a, input logic wr);
      bus.src_htrans = tr;
      bus.src_haddr  = a;
      bus.src_hwrite = wr;
   endtask

   task automatic rsp(input int p, input logic rdy, input logic err, input logic xok,
                      input logic [31:0] d);
      bus.dst_hready_resp[p]    = rdy;
      bus.dst_hresp[p]          = err;
      bus.dst_hexokay[p]        = xok;
      bus.dst_hrdata[p*32 +: 32] = d;
   endtask

   // Address windows written as plain ranges.
   function automatic int port_of(input logic [31:0] a);
      if (a >= 32'h4000_0000 && a < 32'h5000_0000) return 1;
      if (a < 32'h1000_0000) return 0;
      return -1;
   endfunction

   // Model: dp = -1 idle, 0/1 slave owns data phase, 2 local error; ecnt = error cycle.
   int               dp;
   int               ecnt;
   logic [NP-1:0]    s_rdy, s_err, s_xok;
   logic [WD-1:0]    s_rd [NP];

   initial begin
      logic [31:0] addr;
      logic [1:0]  tr;
      logic [3:0]  nib;
      logic [3:0]  exp_tr;
      logic        e_rdy, e_err, e_xok, hr;
      logic [31:0] e_rd;
      logic [1:0]  e_sel;
      int          pt;

      drive(2'b00, 32'h0, 1'b0);
      bus.src_hsize = 3'd2; bus.src_hburst = 3'd0; bus.src_hprot = 4'h3;
      bus.src_hmastlock = 1'b0; bus.src_hexcl = 1'b0; bus.src_hmaster = 8'h00;
      bus.src_hwdata = 32'h0;
      rsp(0, 1'b1, 1'b0, 1'b0, 32'h0);
      rsp(1, 1'b1, 1'b0, 1'b0, 32'h0);

      // Reset
      repeat (3) next_cycle();
      rst_n = 1'b1;
      #2;
      chk("rst_ready", bus.src_hready_resp, 1);
      chk("rst_hresp", bus.src_hresp, 0);
      chk("rst_sel", bus.slave_sel_d, 0);
      chk("rst_htrans", bus.dst_htrans, 0);
      chk("rst_hexokay", bus.src_hexokay, 0);
      chk("rst_hrdata", bus.src_hrdata, 0);

      // Mapped read with one wait state
      next_cycle();
      drive(2'b10, 32'h0000_0010, 1'b0);
      rsp(0, 1'b0, 1'b0, 1'b0, 32'h0);
      #2;
      chk("rd_htrans", bus.dst_htrans, 4'b0010);
      next_cycle();
      drive(2'b00, 32'h0, 1'b0);
      #2;
      chk("rd_sel", bus.slave_sel_d, 2'b01);
      chk("rd_wait", bus.src_hready_resp, 0);
      next_cycle();
      rsp(0, 1'b1, 1'b0, 1'b0, 32'hDEAD_BEEF);
      #2;
      chk("rd_ready", bus.src_hready_resp, 1);
      chk("rd_hrdata", bus.src_hrdata, 32'hDEAD_BEEF);
      next_cycle();
      #2;
      chk("rd_idle_sel", bus.slave_sel_d, 0);
      chk("rd_idle_hrdata", bus.src_hrdata, 0);

      // Back-to-back: write slave1 then read slave0
      next_cycle();
      drive(2'b10, 32'h4000_0004, 1'b1);
      rsp(0, 1'b1, 1'b0, 1'b0, 32'h0);
      #2;
      chk("b2b_htrans1", bus.dst_htrans, 4'b1000);
      next_cycle();
      drive(2'b10, 32'h0000_0008, 1'b0);
      bus.src_hwdata = 32'h1234_5678;
      #2;
      chk("b2b_sel1", bus.slave_sel_d, 2'b10);
      chk("b2b_hwdata1", bus.dst_hwdata[63:32], 32'h1234_5678);
      chk("b2b_htrans0", bus.dst_htrans, 4'b0010);
      chk("b2b_ready1", bus.src_hready_resp, 1);
      next_cycle();
      drive(2'b00, 32'h0, 1'b0);
      rsp(0, 1'b1, 1'b0, 1'b0, 32'hCAFE_0001);
      #2;
      chk("b2b_sel0", bus.slave_sel_d, 2'b01);
      chk("b2b_hrdata0", bus.src_hrdata, 32'hCAFE_0001);

      // Unmapped, then mapped transfer accepted in ERR2
      next_cycle();
      drive(2'b10, 32'h8000_0000, 1'b0);
      #2;
      chk("um_htrans", bus.dst_htrans, 0);
      next_cycle();
      drive(2'b00, 32'h0, 1'b0);
      #2;
      chk("um_e1_ready", bus.src_hready_resp, 0);
      chk("um_e1_hresp", bus.src_hresp, 1);
      chk("um_e1_sel", bus.slave_sel_d, 0);
      next_cycle();
      drive(2'b10, 32'h4000_0000, 1'b0);
      #2;
      chk("um_e2_ready", bus.src_hready_resp, 1);
      chk("um_e2_hresp", bus.src_hresp, 1);
      chk("um_e2_htrans", bus.dst_htrans, 4'b1000);
      next_cycle();
      drive(2'b00, 32'h0, 1'b0);
      #2;
      chk("em_sel", bus.slave_sel_d, 2'b10);
      chk("em_hresp", bus.src_hresp, 0);
      chk("em_ready", bus.src_hready_resp, 1);

      // Exclusive write to slave1
      next_cycle();
      drive(2'b10, 32'h4000_0010, 1'b1);
      bus.src_hexcl = 1'b1;
      bus.src_hmaster = 8'h5A;
      #2;
      chk("ex_hexcl", bus.dst_hexcl, 2'b11);
      chk("ex_hmaster", bus.dst_hmaster, 16'h5A5A);
      next_cycle();
      drive(2'b00, 32'h0, 1'b0);
      bus.src_hexcl = 1'b0;
      rsp(0, 1'b1, 1'b0, 1'b1, 32'h0);
      rsp(1, 1'b1, 1'b0, 1'b1, 32'h0);
      #2;
      chk("ex_okay", bus.src_hexokay, 1);
      next_cycle();
      #2;
      chk("ex_okay_idle", bus.src_hexokay, 0);
      rsp(0, 1'b1, 1'b0, 1'b0, 32'h0);
      rsp(1, 1'b1, 1'b0, 1'b0, 32'h0);

      // HREADY low freezes the data-phase select
      next_cycle();
      hold_low = 1'b1;
      drive(2'b10, 32'h0000_0020, 1'b0);
      #2;
      chk("frz_htrans", bus.dst_htrans, 4'b0010);
      chk("frz_hready", bus.dst_hready, 2'b00);
      next_cycle();
      #2;
      chk("frz_sel", bus.slave_sel_d, 0);
      hold_low = 1'b0;
      next_cycle();
      drive(2'b00, 32'h0, 1'b0);
      #2;
      chk("frz_release_sel", bus.slave_sel_d, 2'b01);

      // Asynchronous reset during ERR1
      next_cycle();
      drive(2'b10, 32'h9000_0000, 1'b0);
      next_cycle();
      drive(2'b00, 32'h0, 1'b0);
      #2;
      chk("rerr_e1_ready", bus.src_hready_resp, 0);
      #1;
      rst_n = 1'b0;
      #1;
      chk("rerr_ready", bus.src_hready_resp, 1);
      chk("rerr_hresp", bus.src_hresp, 0);
      chk("rerr_sel", bus.slave_sel_d, 0);
      next_cycle();
      rst_n = 1'b1;

      // Randomized traffic against the transfer-level model
      dp = -1;
      ecnt = 0;
      for (int c = 0; c < 400; c++) begin
         next_cycle();
         tr = 2'($urandom_range(3, 0));
         addr = $urandom();
         case ($urandom_range(2, 0))
            0:       nib = 4'h0;
            1:       nib = 4'h4;
            default: nib = 4'($urandom_range(15, 0));
         endcase
         addr[31:28] = nib;
         drive(tr, addr, 1'($urandom_range(1, 0)));
         hold_low = ($urandom_range(7, 0) == 0);
         for (int p = 0; p < NP; p++) begin
            s_rdy[p] = ($urandom_range(3, 0) != 0);
            s_err[p] = ($urandom_range(7, 0) == 0);
            s_xok[p] = 1'($urandom_range(1, 0));
            s_rd[p]  = $urandom();
            rsp(p, s_rdy[p], s_err[p], s_xok[p], s_rd[p]);
         end
         #2;
         pt = port_of(addr);
         exp_tr = 4'b0000;
         if (tr[1] && pt == 0) exp_tr[1:0] = tr;
         if (tr[1] && pt == 1) exp_tr[3:2] = tr;
         e_rdy = 1'b1; e_err = 1'b0; e_xok = 1'b0; e_rd = 32'h0; e_sel = 2'b00;
         if (dp == 2) begin
            e_rdy = (ecnt == 2);
            e_err = 1'b1;
         end else if (dp >= 0) begin
            e_rdy = s_rdy[dp]; e_err = s_err[dp]; e_xok = s_xok[dp]; e_rd = s_rd[dp];
            e_sel = (dp == 0) ? 2'b01 : 2'b10;
         end
         chk("rnd_sel", bus.slave_sel_d, e_sel);
         chk("rnd_ready", bus.src_hready_resp, e_rdy);
         chk("rnd_hresp", bus.src_hresp, e_err);
         chk("rnd_hexokay", bus.src_hexokay, e_xok);
         chk("rnd_hrdata", bus.src_hrdata, e_rd);
         chk("rnd_htrans", bus.dst_htrans, exp_tr);
         hr = e_rdy & ~hold_low;
         if (dp == 2 && ecnt == 1) begin
            ecnt = 2;
         end else if (dp == 2) begin
            if (hr && tr[1]) begin
               if (pt < 0) ecnt = 1;
               else dp = pt;
            end else begin
               dp = -1;
            end
         end else if (hr) begin
            if (!tr[1]) dp = -1;
            else if (pt < 0) begin dp = 2; ecnt = 1; end
            else dp = pt;
         end
      end
      hold_low = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
